// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register remaining-latency counters for loads,
// multiplies and the variable-latency divider, driving stall, cause and a stall counter.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid_i,
  input  logic [REG_AW-1:0]      id_rs1_i,
  input  logic [REG_AW-1:0]      id_rs2_i,
  input  logic                   id_rs1_used_i,
  input  logic                   id_rs2_used_i,
  input  logic [REG_AW-1:0]      id_rd_i,
  input  logic                   id_rd_we_i,
  input  logic [1:0]             id_op_class_i,
  input  logic                   flush_i,
  input  logic                   freeze_i,
  input  logic                   div_done_i,
  input  logic [REG_AW-1:0]      div_rd_i,
  output logic                   stall_o,
  output logic [1:0]             stall_cause_o,
  output logic                   div_busy_o,
  output logic [2**REG_AW-1:0]   pending_mask_o,
  output logic [CNT_W-1:0]       stall_cycles_o
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam int MAX_LAT  = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int CW       = $clog2(MAX_LAT + 2);
  // All-ones marks an outstanding divide: it never decrements, only div_done clears it.
  localparam logic [CW-1:0] DIV = {CW{1'b1}};

  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  logic [CW-1:0]    cnt_q [NUM_REGS];
  logic [CW-1:0]    cnt_d [NUM_REGS];
  logic             div_busy_q, div_busy_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic          raw, waw, strc, stall;
  logic          issue_ok, issue_wr, issue_div;
  logic [CW-1:0] issue_val;

  always_comb begin
    raw  = (id_rs1_used_i && (cnt_q[id_rs1_i] != '0)) ||
           (id_rs2_used_i && (cnt_q[id_rs2_i] != '0));
    waw  = id_rd_we_i && (id_rd_i != '0) && (cnt_q[id_rd_i] == DIV);
    strc = (id_op_class_i == OP_DIV) && div_busy_q;
    stall = id_valid_i && !flush_i && (raw || waw || strc);

    stall_cause_o = 2'd0;
    if (stall) begin
      if (raw)      stall_cause_o = 2'd1;
      else if (waw) stall_cause_o = 2'd2;
      else          stall_cause_o = 2'd3;
    end

    issue_ok  = id_valid_i && !stall && !flush_i && !freeze_i;
    issue_wr  = issue_ok && id_rd_we_i && (id_rd_i != '0);
    issue_div = issue_ok && (id_op_class_i == OP_DIV);

    case (id_op_class_i)
      OP_LOAD: issue_val = CW'(LOAD_LAT);
      OP_MUL:  issue_val = CW'(MUL_LAT);
      OP_DIV:  issue_val = DIV;
      default: issue_val = '0;
    endcase
  end

  // Priority per register: decrement, then divide completion, then a new issue wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!freeze_i && (cnt_q[r] != '0) && (cnt_q[r] != DIV))
        cnt_d[r] = cnt_q[r] - CW'(1);
      if (div_done_i && (div_rd_i == REG_AW'(r)) && (cnt_q[r] == DIV))
        cnt_d[r] = '0;
      if (issue_wr && (id_rd_i == REG_AW'(r)))
        cnt_d[r] = issue_val;
    end
    cnt_d[0] = '0;

    div_busy_d = div_busy_q;
    if (div_done_i) div_busy_d = 1'b0;
    if (issue_div)  div_busy_d = 1'b1;

    stall_cycles_d = stall_cycles_q;
    if (stall && !freeze_i && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      div_busy_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      div_busy_q     <= div_busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) pending_mask_o[r] = (cnt_q[r] != '0);
  end

  assign stall_o        = stall;
  assign div_busy_o     = div_busy_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: an abstract latency model checked every cycle,
// plus hand-computed literal checks on stall counts, causes and counter values.
module tb_hazard_scoreboard;

  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 2;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, flush, freeze, div_done;
  logic [4:0]  id_rs1, id_rs2, id_rd, div_rd;
  logic [1:0]  id_op_class;
  logic        stall, div_busy;
  logic [1:0]  stall_cause;
  logic [31:0] pending_mask;
  logic [3:0]  stall_cycles;

  int cmp_chk = 0, cmp_pass = 0, lit_chk = 0, lit_pass = 0;

  hazard_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_rd_we_i(id_rd_we), .id_op_class_i(id_op_class),
    .flush_i(flush), .freeze_i(freeze), .div_done_i(div_done), .div_rd_i(div_rd),
    .stall_o(stall), .stall_cause_o(stall_cause), .div_busy_o(div_busy),
    .pending_mask_o(pending_mask), .stall_cycles_o(stall_cycles)
  );

  always #5 clk = ~clk;

  // Model: integer cycles-remaining per register, a set of registers awaiting a divide.
  int   rem [32];
  bit   divp [32];
  bit   m_busy;
  int   m_cnt;
  logic [1:0] m_c;
  bit   m_iss;

  function automatic bit m_pend(input logic [4:0] r);
    return (r != 0) && (rem[r] > 0 || divp[r]);
  endfunction

  function automatic logic [1:0] m_cause();
    bit r_h, w_h, s_h;
    r_h = (id_rs1_used && m_pend(id_rs1)) || (id_rs2_used && m_pend(id_rs2));
    w_h = id_rd_we && id_rd != 0 && divp[id_rd];
    s_h = id_op_class == 2'd3 && m_busy;
    if (!id_valid || flush) return 2'd0;
    if (r_h) return 2'd1;
    if (w_h) return 2'd2;
    if (s_h) return 2'd3;
    return 2'd0;
  endfunction

  initial begin : model
    for (int r = 0; r < 32; r++) begin rem[r] = 0; divp[r] = 0; end
    m_busy = 0; m_cnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int r = 0; r < 32; r++) begin rem[r] = 0; divp[r] = 0; end
        m_busy = 0; m_cnt = 0;
      end else begin
        m_c   = m_cause();
        m_iss = id_valid && m_c == 0 && !flush && !freeze;
        if (m_c != 0 && !freeze && m_cnt < CNT_MAX) m_cnt++;
        if (!freeze) for (int r = 0; r < 32; r++) if (rem[r] > 0) rem[r]--;
        if (div_done) begin divp[div_rd] = 0; m_busy = 0; end
        if (m_iss && id_rd_we && id_rd != 0) begin
          rem[id_rd]  = (id_op_class == 2'd1) ? LOAD_LAT : (id_op_class == 2'd2) ? MUL_LAT : 0;
          divp[id_rd] = (id_op_class == 2'd3);
        end
        if (m_iss && id_op_class == 2'd3) m_busy = 1;
      end
    end
  end

  initial begin : compare
    logic [1:0]  ec;
    logic [31:0] em;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ec = m_cause();
        em = '0;
        for (int r = 0; r < 32; r++) em[r] = m_pend(5'(r));
        cmp_chk += 5;
        if (stall == (ec != 0)) cmp_pass++;
        else $display("FAIL cyc_stall t=%0t got %0b want %0b", $time, stall, ec != 0);
        if (stall_cause == ec) cmp_pass++;
        else $display("FAIL cyc_cause t=%0t got %0d want %0d", $time, stall_cause, ec);
        if (div_busy == m_busy) cmp_pass++;
        else $display("FAIL cyc_div_busy t=%0t got %0b want %0b", $time, div_busy, m_busy);
        if (pending_mask == em) cmp_pass++;
        else $display("FAIL cyc_pending t=%0t got %h want %h", $time, pending_mask, em);
        if (int'(stall_cycles) == m_cnt) cmp_pass++;
        else $display("FAIL cyc_stall_cycles t=%0t got %0d want %0d", $time, stall_cycles, m_cnt);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    lit_chk++;
    if (act == exp) lit_pass++;
    else $display("FAIL %s got %0d want %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic [1:0] op);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_op_class = op;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    idle(); flush = 0; freeze = 0; div_done = 0; div_rd = 0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Counts cycles with stall high; freeze is held on samples f_lo..f_hi.
  task automatic count_stalls(input int f_lo, input int f_hi, output int n);
    n = 0;
    while (stall && n < 40) begin
      freeze = (n >= f_lo && n <= f_hi);
      step();
      n++;
    end
    freeze = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    idle(); flush = 0; freeze = 0; div_done = 0; div_rd = 0;
    rst_n = 1'b0;
    #2;
    lit("reset_stall", int'(stall), 0);
    lit("reset_cause", int'(stall_cause), 0);
    lit("reset_pending", int'(pending_mask != 0), 0);
    lit("reset_cycles", int'(stall_cycles), 0);
    #10 rst_n = 1'b1;
    step();

    // lw x5 ; add x6,x5,x1
    set_id(1, 0, 0, 0, 0, 5, 1, 2'd1); step();
    set_id(1, 5, 1, 1, 1, 6, 1, 2'd0); #1;
    lit("load_stall", int'(stall), 1);
    lit("load_cause", int'(stall_cause), 1);
    lit("load_pend5", int'(pending_mask[5]), 1);
    count_stalls(-1, -1, n);
    lit("load_bubbles", n, 1);
    lit("load_cycles", int'(stall_cycles), 1);
    lit("load_pend5_clr", int'(pending_mask[5]), 0);
    idle(); step();

    // mul x7 ; dependent
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 2'd2); step();
    set_id(1, 3, 1, 7, 1, 8, 1, 2'd0); #1;
    count_stalls(-1, -1, n);
    lit("mul_bubbles", n, 2);
    lit("mul_cycles", int'(stall_cycles), 2);
    idle(); step();

    // mul x7 ; dependent with a 3-cycle freeze in the middle
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 2'd2); step();
    set_id(1, 7, 1, 3, 1, 8, 1, 2'd0); #1;
    count_stalls(1, 3, n);
    lit("mulfrz_stall_len", n, 5);
    lit("mulfrz_cycles", int'(stall_cycles), 2);
    idle(); step();

    // div x9 ; add x10,x9,x0 ; WAW and structural probes ; completion
    do_reset();
    set_id(1, 0, 0, 0, 0, 9, 1, 2'd3); step();
    set_id(1, 9, 1, 0, 1, 10, 1, 2'd0); #1;
    lit("div_raw_cause", int'(stall_cause), 1);
    lit("div_busy", int'(div_busy), 1);
    repeat (4) step();
    lit("div_still_stall", int'(stall), 1);
    set_id(1, 1, 1, 0, 0, 9, 1, 2'd0); #1;
    lit("div_waw_cause", int'(stall_cause), 2);
    set_id(1, 2, 1, 0, 0, 11, 1, 2'd3); #1;
    lit("div_strc_cause", int'(stall_cause), 3);
    step();
    set_id(1, 9, 1, 0, 1, 10, 1, 2'd0);
    div_done = 1; div_rd = 9; #1;
    lit("div_done_cycle_stall", int'(stall), 1);
    step();
    div_done = 0; #1;
    lit("div_after_stall", int'(stall), 0);
    lit("div_after_busy", int'(div_busy), 0);
    set_id(1, 1, 1, 0, 0, 9, 1, 2'd0); #1;
    lit("waw_cleared", int'(stall), 0);
    set_id(1, 2, 1, 0, 0, 11, 1, 2'd3); #1;
    lit("strc_cleared", int'(stall), 0);
    step();
    idle(); step();

    // lw x0 ; reader of x0 ; div x0 still marks the divider busy
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 2'd1); step();
    set_id(1, 0, 1, 0, 1, 4, 1, 2'd0); #1;
    lit("x0_no_stall", int'(stall), 0);
    lit("x0_no_pending", int'(pending_mask != 0), 0);
    set_id(1, 0, 0, 0, 0, 0, 1, 2'd3); step();
    idle(); #1;
    lit("div_x0_busy", int'(div_busy), 1);
    lit("div_x0_pending", int'(pending_mask != 0), 0);
    div_done = 1; div_rd = 0; step();
    div_done = 0; #1;
    lit("div_x0_busy_clr", int'(div_busy), 0);

    // flush: killed load records nothing; flushed dependent does not stall
    set_id(1, 0, 0, 0, 0, 12, 1, 2'd1); flush = 1; step();
    flush = 0; idle(); #1;
    lit("flush_no_issue", int'(pending_mask[12]), 0);
    set_id(1, 0, 0, 0, 0, 5, 1, 2'd1); step();
    set_id(1, 5, 1, 1, 1, 6, 1, 2'd0); flush = 1; #1;
    lit("flush_no_stall", int'(stall), 0);
    step();
    flush = 0; idle(); step();

    // reset mid-divide
    set_id(1, 0, 0, 0, 0, 9, 1, 2'd3); step();
    set_id(1, 9, 1, 0, 0, 10, 1, 2'd0); #1;
    lit("pre_rst_stall", int'(stall), 1);
    rst_n = 1'b0; #1;
    lit("rst_stall", int'(stall), 0);
    lit("rst_cause", int'(stall_cause), 0);
    lit("rst_busy", int'(div_busy), 0);
    lit("rst_pending", int'(pending_mask != 0), 0);
    lit("rst_cycles", int'(stall_cycles), 0);
    idle(); rst_n = 1'b1; step();

    // saturation of the 4-bit stall counter
    do_reset();
    set_id(1, 0, 0, 0, 0, 9, 1, 2'd3); step();
    set_id(1, 9, 1, 0, 0, 10, 1, 2'd0);
    repeat (20) step();
    lit("sat_cycles", int'(stall_cycles), 15);
    div_done = 1; div_rd = 9; step();
    div_done = 0; #1;
    lit("sat_after_done", int'(stall), 0);
    lit("sat_hold", int'(stall_cycles), 15);
    idle(); step(); step();

    $display("%0d/%0d checks passed", cmp_pass + lit_pass, cmp_chk + lit_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use detector. Lives in ID and drives the IF/ID hold and the ID/EX bubble.
- Tracks the remaining result latency of every in-flight long-latency writer (loads, fixed-latency multiply, variable-latency divide) in a per-register scoreboard.
- Stalls ID on RAW hazards, WAW against an outstanding divide, and divider structural conflicts.
- Reports the stall cause and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW.
- LOAD_LAT, 1, stall cycles a dependent instruction sees directly behind a load (1 = classic load-use).
- MUL_LAT, 2, stall cycles a dependent instruction sees directly behind a multiply.
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  REG_AW each  ID source register addresses
- id_rs1_used, id_rs2_used  in  1 each  source field is a real register read
- id_rd  in  REG_AW  ID destination register
- id_rd_we  in  1  ID instruction writes id_rd
- id_op_class  in  2  0 ALU/single-cycle, 1 load, 2 multiply, 3 divide
- flush  in  1  ID instruction is being killed this cycle
- freeze  in  1  whole pipeline held (e.g. memory not ready)
- div_done  in  1  divider result written back this cycle
- div_rd  in  REG_AW  destination of the completing divide
- stall  out  1  hold IF/ID and inject a bubble into EX
- stall_cause  out  2  0 none, 1 RAW, 2 WAW-on-divide, 3 divider busy
- div_busy  out  1  a divide is outstanding
- pending_mask  out  NUM_REGS  bit r set when reg r has a nonzero counter
- stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- State:
  - cnt[r] for r = 1..NUM_REGS-1, width CW = clog2(max(LOAD_LAT,MUL_LAT)+2).
  - All-ones in cnt[r] is the DIV marker, meaning "non-decrementing, wait for div_done".
  - div_busy_q; stall_cycles.
  - Register 0 is never tracked; cnt[0] reads as 0.
- Reset (rst_n low, asynchronous): all cnt = 0, div_busy = 0, stall_cycles = 0. Hence stall = 0, stall_cause = 0, pending_mask = 0. Reset mid-operation discards all pending entries.
- Hazard terms (combinational from registered state and ID inputs):
  - raw = (id_rs1_used & cnt[id_rs1] != 0) | (id_rs2_used & cnt[id_rs2] != 0)
  - waw = id_rd_we & id_rd != 0 & cnt[id_rd] == DIV
  - strc = id_op_class == 3 & div_busy
- Stall output:
  - stall = id_valid & !flush & (raw | waw | strc).
  - stall_cause priority: RAW, then WAW, then divider busy; 0 when stall = 0.
  - flush forces stall = 0.
- Issue: issue = id_valid & !stall & !flush & !freeze & id_rd_we & id_rd != 0. On the clock edge after issue:
  - class 1: cnt[id_rd] = LOAD_LAT
  - class 2: cnt[id_rd] = MUL_LAT
  - class 3: cnt[id_rd] = DIV, div_busy = 1
  - class 0: cnt[id_rd] = 0 (a younger single-cycle writer overrides, since forwarding covers it)
  - A class 3 instruction with rd = 0 still sets div_busy.
- Decrement: each edge with freeze = 0, every cnt that is nonzero and not DIV decrements by 1. When freeze = 1, all counters and div_busy hold.
- Divide completion: div_done clears cnt[div_rd] if it equals DIV, and clears div_busy. This applies regardless of freeze.
- Simultaneous events on the same register in one edge: issue beats decrement and beats div_done clear.
- Latency example, LOAD_LAT = 1:
  - load issues at edge E; dependent instruction is in ID in cycle E+1 and sees cnt = 1, so stall.
  - edge E+1 decrements; cycle E+2 has no stall.
  - Result: exactly LOAD_LAT bubbles.
- pending_mask: registered view, bit r = (cnt[r] != 0).
- stall_cycles: increments on each edge where stall & !freeze; saturates at all-ones with no wrap.

Test Plan:
- Reset, LOAD_LAT = 1: issue `lw x5`, then `add x6,x5,x1` in ID -> stall = 1, cause = 1 for exactly 1 cycle; stall_cycles = 1; pending_mask[5] high for 1 cycle.
- MUL_LAT = 2: issue `mul x7`, dependent on x7 follows -> 2 stall cycles. Same sequence with freeze = 1 for 3 cycles in the middle -> stall persists 5 cycles, stall_cycles counts 2 (frozen cycles not counted).
- Issue `div x9`; then `add x10,x9,x0` -> stall, cause 1, until div_done with div_rd = 9; the cycle after div_done -> stall = 0, div_busy = 0.
- With the x9 divide outstanding: `addi x9` in ID -> cause 2 (WAW); `div x11` in ID -> cause 3. Both clear after div_done.
- `lw x0` then a reader of x0 -> never stalls. Load to x5 with a dependent in ID and flush = 1 -> stall = 0, no issue recorded. Assert rst_n low mid-divide -> all outputs 0 asynchronously.
- Preload stall_cycles near saturation (CNT_W = 4, 20 consecutive stall cycles) -> holds at 15.
